fifo_queue_reader: RTL and testbench

// Consumer-side engine for a memory-resident circular FIFO. Compares its read pointer to the producer's

---
 rtl/fifo_queue_reader_if.sv | 37 +++
 rtl/fifo_queue_reader.sv | 132 +++++++++++++
 tb/tb_fifo_queue_reader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_queue_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_queue_reader_if
// Description : Memory read port plus downstream element stream of the queue reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_queue_reader_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_resp_valid;
    logic [DATA_W-1:0] rd_resp_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // master = the reader engine, slave = memory + downstream consumer
    modport master (
        output rd_req_valid, rd_req_addr,
        input  rd_req_ready,
        input  rd_resp_valid, rd_resp_data,
        output out_valid, out_data,
        input  out_ready
    );

    modport slave (
        input  rd_req_valid, rd_req_addr,
        output rd_req_ready,
        output rd_resp_valid, rd_resp_data,
        input  out_valid, out_data,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fifo_queue_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_queue_reader
// Description : Consumer engine for a memory-resident circular FIFO: issues
//               reads up to the producer tail and streams elements in order.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_queue_reader #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int PTR_W  = 16,
    parameter int DEPTH  = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              cfg_enable,
    input  wire logic              cfg_clear,
    input  wire logic [ADDR_W-1:0] cfg_base_addr,
    input  wire logic [PTR_W-1:0]  cfg_len,
    input  wire logic [PTR_W-1:0]  tail_ptr_i,
    output logic      [PTR_W-1:0]  head_ptr_o,
    output logic                   busy_o,
    output logic                   err_o,
    fifo_queue_reader_if.master    bus
);

    localparam int c_cw = $clog2(DEPTH + 1);
    localparam int c_iw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_cw-1:0]   c_depth    = c_cw'(DEPTH);
    localparam logic [c_iw-1:0]   c_idx_last = c_iw'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_stride   = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_head_ptr;
    logic [c_cw-1:0]   r_credits;
    logic [c_cw-1:0]   r_outstanding;
    logic [c_cw-1:0]   r_count;
    logic [c_iw-1:0]   r_wr_idx;
    logic [c_iw-1:0]   r_rd_idx;
    logic              r_req_hold;
    logic              r_err;
    logic [DATA_W-1:0] r_buf [DEPTH];

    logic             w_issue;
    logic             w_req_valid;
    logic             w_req_hs;
    logic             w_resp_ok;
    logic             w_pop;
    logic             w_clear;
    logic [PTR_W-1:0] w_len_last;

    assign w_len_last  = cfg_len - PTR_W'(1);
    assign w_issue     = (r_state == S_RUN) && (r_rd_ptr != tail_ptr_i) && (r_credits < c_depth);
    // A request once raised stays up until accepted, whatever the state does
    assign w_req_valid = w_issue || r_req_hold;
    assign w_req_hs    = w_req_valid && bus.rd_req_ready;
    assign w_resp_ok   = bus.rd_resp_valid && (r_outstanding != '0);
    assign w_pop       = (r_count != '0) && bus.out_ready;
    assign w_clear     = cfg_clear && (r_state == S_IDLE);

    assign bus.rd_req_valid = w_req_valid;
    assign bus.rd_req_addr  = cfg_base_addr + ADDR_W'(r_rd_ptr) * c_stride;
    assign bus.out_valid    = (r_count != '0);
    assign bus.out_data     = r_buf[r_rd_idx];
    assign head_ptr_o       = r_head_ptr;
    assign busy_o           = (r_state != S_IDLE);
    assign err_o            = r_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (cfg_enable) w_state_nxt = S_RUN;
            S_RUN:   if (!cfg_enable) w_state_nxt = S_DRAIN;
            S_DRAIN: if ((r_outstanding == '0) && !w_req_valid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rd_ptr      <= '0;
            r_head_ptr    <= '0;
            r_credits     <= '0;
            r_outstanding <= '0;
            r_count       <= '0;
            r_wr_idx      <= '0;
            r_rd_idx      <= '0;
            r_req_hold    <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_hold <= w_req_valid && !bus.rd_req_ready;
            if (bus.rd_resp_valid && (r_outstanding == '0)) r_err <= 1'b1;
            r_outstanding <= r_outstanding + c_cw'(w_req_hs) - c_cw'(w_resp_ok);
            if (w_clear) begin
                r_rd_ptr   <= '0;
                r_head_ptr <= '0;
                r_credits  <= '0;
                r_count    <= '0;
                r_wr_idx   <= '0;
                r_rd_idx   <= '0;
            end else begin
                if (w_req_hs)
                    r_rd_ptr <= (r_rd_ptr == w_len_last) ? '0 : r_rd_ptr + PTR_W'(1);
                if (w_pop) begin
                    r_head_ptr <= (r_head_ptr == w_len_last) ? '0 : r_head_ptr + PTR_W'(1);
                    r_rd_idx   <= (r_rd_idx == c_idx_last) ? '0 : r_rd_idx + c_iw'(1);
                end
                if (w_resp_ok)
                    r_wr_idx <= (r_wr_idx == c_idx_last) ? '0 : r_wr_idx + c_iw'(1);
                r_credits <= r_credits + c_cw'(w_req_hs) - c_cw'(w_pop);
                r_count   <= r_count + c_cw'(w_resp_ok) - c_cw'(w_pop);
            end
        end
    end

    // Storage needs no reset: r_count gates visibility of every entry
    always_ff @(posedge clk) begin
        if (w_resp_ok) r_buf[r_wr_idx] <= bus.rd_resp_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_queue_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_queue_reader
// Description : Directed self-checking bench with an in-order memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_queue_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_enable = 1'b0;
    logic        cfg_clear = 1'b0;
    logic [63:0] base = 64'h1000;
    logic [15:0] len = 16'd8;
    logic [15:0] tail = 16'd0;
    logic [15:0] head_ptr_o;
    logic        busy_o;
    logic        err_o;

    int          checks = 0;
    int          failures = 0;
    longint      cyc = 0;
    int          mem_lat = 1;
    bit          mem_ready = 1'b0;
    logic [63:0] mem_addr_q [$];
    longint      mem_due_q [$];
    logic [63:0] req_log [$];
    logic [63:0] got_q [$];

    fifo_queue_reader_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    fifo_queue_reader #(.ADDR_W(64), .DATA_W(64), .PTR_W(16), .DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_enable    (cfg_enable),
        .cfg_clear     (cfg_clear),
        .cfg_base_addr (base),
        .cfg_len       (len),
        .tail_ptr_i    (tail),
        .head_ptr_o    (head_ptr_o),
        .busy_o        (busy_o),
        .err_o         (err_o),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_data(input logic [63:0] a);
        return 64'hC0DE_0000_0000_0000 ^ (a * 64'd3);
    endfunction

    // Memory responder and output monitor; drives at negedge+1, samples at negedge+2
    initial begin : mem_model
        bus.rd_req_ready  = 1'b0;
        bus.rd_resp_valid = 1'b0;
        bus.rd_resp_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            #1;
            if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
                bus.rd_resp_valid = 1'b1;
                bus.rd_resp_data  = mem_data(mem_addr_q.pop_front());
                void'(mem_due_q.pop_front());
            end else begin
                bus.rd_resp_valid = 1'b0;
                bus.rd_resp_data  = '0;
            end
            bus.rd_req_ready = mem_ready;
            #1;
            if (bus.rd_req_valid && bus.rd_req_ready) begin
                mem_addr_q.push_back(bus.rd_req_addr);
                mem_due_q.push_back(cyc + longint'(mem_lat));
                req_log.push_back(bus.rd_req_addr);
            end
            if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cfg_enable = 1'b0; cfg_clear = 1'b0; mem_ready = 1'b0; bus.out_ready = 1'b0;
        tick(3);
        mem_addr_q.delete(); mem_due_q.delete();
        tick(1);
        rst = 1'b0; mem_ready = 1'b1; tail = 16'd0; base = 64'h1000; len = 16'd8; mem_lat = 1;
        req_log.delete(); got_q.delete();
    endtask

    task automatic go_idle(output bit ok);
        int n = 0;
        @(negedge clk);
        cfg_enable = 1'b0;
        while (busy_o && n < 30) begin
            @(negedge clk);
            n++;
        end
        ok = !busy_o;
    endtask

    task automatic test_reset();
        do_reset();
        tick(1); #3;
        checks++; if (bus.rd_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got %b want 0", bus.rd_req_valid); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", err_o); end
        checks++; if (head_ptr_o !== 16'd0) begin failures++; $display("FAIL reset_head got %0d want 0", head_ptr_o); end
        checks++; if (bus.rd_req_addr !== 64'h1000) begin failures++; $display("FAIL reset_addr got %h want 1000", bus.rd_req_addr); end
    endtask

    task automatic test_basic();
        logic [63:0] e [3];
        logic [63:0] a;
        logic [63:0] d;
        bit ok;
        int n = 0;
        e = '{64'h1000, 64'h1008, 64'h1010};
        req_log.delete(); got_q.delete();
        tick(1);
        len = 16'd8; tail = 16'd3; bus.out_ready = 1'b1; mem_lat = 1; cfg_enable = 1'b1;
        while (got_q.size() < 3 && n < 40) begin tick(1); n++; end
        #3;
        checks++; if (got_q.size() != 3) begin failures++; $display("FAIL basic_count got %0d want 3", got_q.size()); end
        checks++; if (req_log.size() != 3) begin failures++; $display("FAIL basic_reqs got %0d want 3", req_log.size()); end
        for (int i = 0; i < 3; i++) begin
            a = (i < req_log.size()) ? req_log[i] : 'x;
            d = (i < got_q.size()) ? got_q[i] : 'x;
            checks++; if (a !== e[i]) begin failures++; $display("FAIL basic_addr%0d got %h want %h", i, a, e[i]); end
            checks++; if (d !== mem_data(e[i])) begin failures++; $display("FAIL basic_data%0d got %h want %h", i, d, mem_data(e[i])); end
        end
        checks++; if (head_ptr_o !== 16'd3) begin failures++; $display("FAIL basic_head got %0d want 3", head_ptr_o); end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL basic_busy got %b want 1", busy_o); end
        checks++; if (bus.rd_req_valid !== 1'b0) begin failures++; $display("FAIL basic_empty_valid got %b want 0", bus.rd_req_valid); end
        go_idle(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_idle got busy=%b want 0", busy_o); end
    endtask

    task automatic test_wrap();
        logic [63:0] a;
        bit ok;
        req_log.delete(); got_q.delete();
        tick(1);
        len = 16'd4; tail = 16'd1; bus.out_ready = 1'b0; cfg_enable = 1'b1;
        tick(10); #3;
        checks++; if (req_log.size() != 2) begin failures++; $display("FAIL wrap_reqs got %0d want 2", req_log.size()); end
        a = (req_log.size() > 0) ? req_log[0] : 'x;
        checks++; if (a !== 64'h1018) begin failures++; $display("FAIL wrap_addr0 got %h want 1018", a); end
        a = (req_log.size() > 1) ? req_log[1] : 'x;
        checks++; if (a !== 64'h1000) begin failures++; $display("FAIL wrap_addr1 got %h want 1000", a); end
        checks++; if (head_ptr_o !== 16'd3) begin failures++; $display("FAIL wrap_head3 got %0d want 3", head_ptr_o); end
        checks++; if (bus.out_data !== mem_data(64'h1018)) begin failures++; $display("FAIL wrap_data0 got %h want %h", bus.out_data, mem_data(64'h1018)); end
        tick(1); bus.out_ready = 1'b1;
        tick(1); bus.out_ready = 1'b0; #3;
        checks++; if (head_ptr_o !== 16'd0) begin failures++; $display("FAIL wrap_head0 got %0d want 0", head_ptr_o); end
        checks++; if (bus.out_data !== mem_data(64'h1000)) begin failures++; $display("FAIL wrap_data1 got %h want %h", bus.out_data, mem_data(64'h1000)); end
        tick(1); bus.out_ready = 1'b1;
        tick(1); bus.out_ready = 1'b0; #3;
        checks++; if (head_ptr_o !== 16'd1) begin failures++; $display("FAIL wrap_head1 got %0d want 1", head_ptr_o); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL wrap_drained got %b want 0", bus.out_valid); end
        go_idle(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wrap_idle got busy=%b want 0", busy_o); end
    endtask

    task automatic test_backpressure();
        logic [63:0] d;
        bit ok;
        int n = 0;
        tick(1); cfg_clear = 1'b1;
        tick(1); cfg_clear = 1'b0; #3;
        checks++; if (head_ptr_o !== 16'd0) begin failures++; $display("FAIL clear_idle_head got %0d want 0", head_ptr_o); end
        checks++; if (bus.rd_req_addr !== 64'h1000) begin failures++; $display("FAIL clear_idle_addr got %h want 1000", bus.rd_req_addr); end
        req_log.delete(); got_q.delete();
        tick(1);
        len = 16'd8; tail = 16'd7; bus.out_ready = 1'b0; cfg_enable = 1'b1;
        tick(15); #3;
        checks++; if (req_log.size() != 4) begin failures++; $display("FAIL bp_credit_reqs got %0d want 4", req_log.size()); end
        checks++; if (bus.rd_req_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_low got %b want 0", bus.rd_req_valid); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got %b want 1", bus.out_valid); end
        tick(1); bus.out_ready = 1'b1;
        tick(1); bus.out_ready = 1'b0;
        tick(5); #3;
        checks++; if (req_log.size() != 5) begin failures++; $display("FAIL bp_one_more got %0d want 5", req_log.size()); end
        checks++; if (bus.rd_req_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_low2 got %b want 0", bus.rd_req_valid); end
        tick(1); bus.out_ready = 1'b1;
        while (got_q.size() < 7 && n < 40) begin tick(1); n++; end
        #3;
        checks++; if (got_q.size() != 7) begin failures++; $display("FAIL bp_count got %0d want 7", got_q.size()); end
        checks++; if (head_ptr_o !== 16'd7) begin failures++; $display("FAIL bp_head got %0d want 7", head_ptr_o); end
        for (int i = 0; i < 7; i++) begin
            d = (i < got_q.size()) ? got_q[i] : 'x;
            checks++; if (d !== mem_data(64'h1000 + 64'(8 * i))) begin failures++; $display("FAIL bp_data%0d got %h want %h", i, d, mem_data(64'h1000 + 64'(8 * i))); end
        end
        go_idle(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_idle got busy=%b want 0", busy_o); end
    endtask

    task automatic test_req_stall();
        logic [63:0] a;
        bit ok;
        req_log.delete(); got_q.delete();
        tick(1);
        mem_ready = 1'b0; tail = 16'd1; bus.out_ready = 1'b1; cfg_enable = 1'b1;
        tick(1);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (k == 2) tail = 16'd2;
            #3;
            checks++; if (bus.rd_req_valid !== 1'b1) begin failures++; $display("FAIL stall_valid%0d got %b want 1", k, bus.rd_req_valid); end
            checks++; if (bus.rd_req_addr !== 64'h1038) begin failures++; $display("FAIL stall_addr%0d got %h want 1038", k, bus.rd_req_addr); end
        end
        tick(1); cfg_enable = 1'b0;
        tick(2); #3;
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL stall_drain_busy got %b want 1", busy_o); end
        checks++; if (bus.rd_req_valid !== 1'b1) begin failures++; $display("FAIL stall_drain_valid got %b want 1", bus.rd_req_valid); end
        tick(1); mem_ready = 1'b1;
        go_idle(ok);
        #3;
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL stall_idle got busy=%b want 0", busy_o); end
        checks++; if (req_log.size() != 1) begin failures++; $display("FAIL stall_reqs got %0d want 1", req_log.size()); end
        a = (got_q.size() > 0) ? got_q[0] : 'x;
        checks++; if (a !== mem_data(64'h1038)) begin failures++; $display("FAIL stall_data got %h want %h", a, mem_data(64'h1038)); end
        checks++; if (head_ptr_o !== 16'd0) begin failures++; $display("FAIL stall_head got %0d want 0", head_ptr_o); end
    endtask

    task automatic test_clear();
        bit ok;
        int n = 0;
        tick(1);
        tail = 16'd2; bus.out_ready = 1'b1; cfg_enable = 1'b1;
        while (head_ptr_o != 16'd2 && n < 40) begin tick(1); n++; end
        cfg_clear = 1'b1;
        tick(1); cfg_clear = 1'b0; #3;
        checks++; if (head_ptr_o !== 16'd2) begin failures++; $display("FAIL clear_run_head got %0d want 2", head_ptr_o); end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL clear_run_busy got %b want 1", busy_o); end
        tick(1); bus.out_ready = 1'b0; tail = 16'd4;
        tick(8);
        go_idle(ok);
        #3;
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL clear_idle got busy=%b want 0", busy_o); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL idle_buffered got %b want 1", bus.out_valid); end
        checks++; if (bus.out_data !== mem_data(64'h1010)) begin failures++; $display("FAIL idle_data got %h want %h", bus.out_data, mem_data(64'h1010)); end
        tick(1); cfg_clear = 1'b1;
        tick(1); cfg_clear = 1'b0; #3;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL clear_flush got %b want 0", bus.out_valid); end
        checks++; if (head_ptr_o !== 16'd0) begin failures++; $display("FAIL clear_head got %0d want 0", head_ptr_o); end
        checks++; if (bus.rd_req_addr !== 64'h1000) begin failures++; $display("FAIL clear_addr got %h want 1000", bus.rd_req_addr); end
    endtask

    task automatic test_reset_mid();
        tick(1);
        tail = 16'd6; mem_lat = 3; bus.out_ready = 1'b1; cfg_enable = 1'b1;
        tick(3);
        rst = 1'b1; cfg_enable = 1'b0;
        tick(1);
        rst = 1'b0; #3;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_busy got %b want 0", busy_o); end
        checks++; if (head_ptr_o !== 16'd0) begin failures++; $display("FAIL rstmid_head got %0d want 0", head_ptr_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rstmid_err0 got %b want 0", err_o); end
        tick(6); #3;
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL rstmid_stray_err got %b want 1", err_o); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_dropped got %b want 0", bus.out_valid); end
        do_reset();
        tick(1); #3;
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rst_clears_err got %b want 0", err_o); end
    endtask

    initial begin : main
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_req_stall();
        test_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
